// File: rtl/mem_responder_pkg.sv
// Shared constants, state encoding and request payload for the memory responder.
// Contents: byte/address widths, RAM decode width, I/O window base, TX FIFO depth,
//           FSM states (IDLE/TX_WAIT/RX_WAIT) and the fetcher request struct.
package mem_responder_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned RAM_ADDR_W   = 17;
    localparam int unsigned TX_DEPTH_LOG = 3;

    localparam logic [ADDR_W-1:0] IO_BASE       = 32'h0003_0000;
    localparam logic [ADDR_W-1:0] IO_STATUS_OFF = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX_WAIT = 2'd1,
        ST_RX_WAIT = 2'd2
    } state_e;

    // One byte request from the fetcher.
    typedef struct packed {
        logic                is_store;
        logic [ADDR_W-1:0]   addr;
        logic [BYTE_W-1:0]   data;
    } ft_req_t;

endpackage

// File: rtl/mem_tx_fifo.sv
// Circular byte FIFO feeding the TX pins.
// Ports: clk, rst (async active-low), push/push_data, pop, head (0 when empty),
//        full, empty. Push while full is accepted only when a pop frees the slot
//        in the same cycle.
module mem_tx_fifo #(
    parameter int unsigned DepthLog = 3,
    parameter int unsigned Width    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned Depth = 1 << DepthLog;

    logic [Width-1:0]    mem [Depth];
    logic [DepthLog-1:0] wr_ptr;
    logic [DepthLog-1:0] rd_ptr;
    logic [DepthLog:0]   count;
    logic                pop_ok;
    logic                push_ok;

    assign empty   = (count == '0);
    assign full    = count[DepthLog];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally at DepthLog bits; count holds 0..Depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + DepthLog'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + DepthLog'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (DepthLog+1)'(1);
                2'b01:   count <= count - (DepthLog+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the fetcher's byte-serial RAM port.
// RAM loads/stores plus an I/O window at IoBase: stores push a TX FIFO, loads of
// IoBase consume an RX byte. Stalls the fetcher while an I/O access is blocked.
// Ports: clk, rst (async active-low); fetcher side is_valid_from_ft,
//        is_store_from_ft, addr_from_ft, data_from_ft, is_stall_to_ft (comb),
//        is_ready_to_ft, data_to_ft; TX io_tx_data/io_tx_valid/io_tx_ready;
//        RX io_rx_data/io_rx_valid/io_rx_ready.
// Build option: MEM_IO_STATUS_EN adds a status byte at IoBase+4.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned       RamAddrWidth   = RAM_ADDR_W,
    parameter logic [ADDR_W-1:0] IoBase         = IO_BASE,
    parameter int unsigned       TxFifoDepthLog = TX_DEPTH_LOG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_valid_from_ft,
    input  logic              is_store_from_ft,
    input  logic [ADDR_W-1:0] addr_from_ft,
    input  logic [BYTE_W-1:0] data_from_ft,
    output logic              is_stall_to_ft,
    output logic              is_ready_to_ft,
    output logic [BYTE_W-1:0] data_to_ft,
    output logic [BYTE_W-1:0] io_tx_data,
    output logic              io_tx_valid,
    input  logic              io_tx_ready,
    input  logic [BYTE_W-1:0] io_rx_data,
    input  logic              io_rx_valid,
    output logic              io_rx_ready
);

    localparam int unsigned RamDepth = 1 << RamAddrWidth;

    ft_req_t                 req;
    state_e                  state;
    state_e                  state_next;
    logic [BYTE_W-1:0]       ram [RamDepth];
    logic [RamAddrWidth-1:0] ram_idx;
    logic                    req_io;
    logic                    req_data_reg;
    logic                    tx_full;
    logic                    tx_empty;
    logic                    tx_pop;
    logic                    tx_push;
    logic                    tx_blocked;
    logic                    stall_c;
    logic                    accept;
    logic                    ram_we;
    logic                    ready_next;
    logic                    rx_ready_next;
    logic [BYTE_W-1:0]       load_byte;

    assign req          = '{is_store: is_store_from_ft, addr: addr_from_ft, data: data_from_ft};
    assign req_io       = (req.addr >= IoBase);
    assign req_data_reg = (req.addr == IoBase);
    assign ram_idx      = req.addr[RamAddrWidth-1:0];

    assign tx_pop      = !tx_empty && io_tx_ready;
    assign io_tx_valid = !tx_empty;

    // Next state and stall; every I/O store targets the TX FIFO, only IoBase loads use RX.
    always_comb begin : fsm_next
        state_next = ST_IDLE;
        stall_c    = 1'b0;
        tx_blocked = tx_full;
        // A held store in TX_WAIT goes through in the cycle the sink frees a slot.
        if (state == ST_TX_WAIT) tx_blocked = tx_full && !tx_pop;
        if (is_valid_from_ft && req_io) begin
            if (req.is_store && tx_blocked) begin
                stall_c    = 1'b1;
                state_next = ST_TX_WAIT;
            end else if (!req.is_store && req_data_reg && !io_rx_valid) begin
                stall_c    = 1'b1;
                state_next = ST_RX_WAIT;
            end
        end
    end

    // Stall is combinational; forced low while reset is held.
    assign is_stall_to_ft = rst && stall_c;

    assign accept        = is_valid_from_ft && !stall_c;
    assign tx_push       = accept && req_io && req.is_store;
    assign ram_we        = accept && !req_io && req.is_store;
    assign ready_next    = accept && !req.is_store;
    assign rx_ready_next = ready_next && req_io && req_data_reg;

    // Load data source: RAM, RX byte, optional status, else zero.
    always_comb begin : load_mux
        load_byte = ram[ram_idx];
        if (req_io) begin
            load_byte = '0;
            if (req_data_reg) load_byte = io_rx_data;
`ifdef MEM_IO_STATUS_EN
            if (req.addr == IoBase + IO_STATUS_OFF) load_byte = {6'b0, tx_full, io_rx_valid};
`else
            // Without the status option IoBase+4 reads as zero like other I/O addresses.
`endif
        end
    end

    // State register and registered fetcher/RX outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            is_ready_to_ft <= 1'b0;
            data_to_ft     <= '0;
            io_rx_ready    <= 1'b0;
        end else begin
            state          <= state_next;
            is_ready_to_ft <= ready_next;
            io_rx_ready    <= rx_ready_next;
            if (ready_next) data_to_ft <= load_byte;
        end
    end

    // Byte RAM, not reset; upper address bits below IoBase alias.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= req.data;
    end

    mem_tx_fifo #(
        .DepthLog (TxFifoDepthLog),
        .Width    (BYTE_W)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (req.data),
        .pop       (tx_pop),
        .head      (io_tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;

    localparam logic [31:0] IOB = 32'h0003_0000;

    logic        clk;
    logic        rst;
    logic        is_valid_from_ft;
    logic        is_store_from_ft;
    logic [31:0] addr_from_ft;
    logic [7:0]  data_from_ft;
    logic        is_stall_to_ft;
    logic        is_ready_to_ft;
    logic [7:0]  data_to_ft;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready;
    logic [7:0]  io_rx_data;
    logic        io_rx_valid;
    logic        io_rx_ready;

    int vec;
    int errs;

    logic [7:0] burst [4];
    logic [7:0] q [$];
    logic [7:0] status_exp;
    int         sent;
    int         got;
    bit         accepted;

    mem_responder dut (
        .clk              (clk),
        .rst              (rst),
        .is_valid_from_ft (is_valid_from_ft),
        .is_store_from_ft (is_store_from_ft),
        .addr_from_ft     (addr_from_ft),
        .data_from_ft     (data_from_ft),
        .is_stall_to_ft   (is_stall_to_ft),
        .is_ready_to_ft   (is_ready_to_ft),
        .data_to_ft       (data_to_ft),
        .io_tx_data       (io_tx_data),
        .io_tx_valid      (io_tx_valid),
        .io_tx_ready      (io_tx_ready),
        .io_rx_data       (io_rx_data),
        .io_rx_valid      (io_rx_valid),
        .io_rx_ready      (io_rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] a, input logic [7:0] d);
        is_valid_from_ft = v;
        is_store_from_ft = s;
        addr_from_ft     = a;
        data_from_ft     = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},    8'(is_stall_to_ft), 8'h00);
        check({tag, "_ready"},    8'(is_ready_to_ft), 8'h00);
        check({tag, "_data"},     data_to_ft,         8'h00);
        check({tag, "_txvalid"},  8'(io_tx_valid),    8'h00);
        check({tag, "_txdata"},   io_tx_data,         8'h00);
        check({tag, "_rxready"},  8'(io_rx_ready),    8'h00);
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33; burst[3] = 8'h44;
`ifdef MEM_IO_STATUS_EN
        status_exp = 8'h02;
`else
        status_exp = 8'h00;
`endif
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        io_tx_ready = 1'b0;
        io_rx_valid = 1'b0;
        io_rx_data  = 8'h00;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Store then immediate load of the same address.
        drive(1'b1, 1'b1, 32'h10, 8'hAB);
        #1 check("raw_store_stall", 8'(is_stall_to_ft), 8'h00);
        tick();
        check("raw_store_no_ready", 8'(is_ready_to_ft), 8'h00);
        drive(1'b1, 1'b0, 32'h10, 8'h00);
        tick();
        check("raw_ready", 8'(is_ready_to_ft), 8'h01);
        check("raw_data",  data_to_ft,         8'hAB);

        // Preload 0x20..0x23, then four back-to-back loads.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h20 + 32'(i), burst[i]);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h20 + 32'(i), 8'h00);
            tick();
            check("burst_ready", 8'(is_ready_to_ft), 8'h01);
            check("burst_data",  data_to_ft,         burst[i]);
        end
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        tick();
        check("burst_idle_ready", 8'(is_ready_to_ft), 8'h00);

        // Address 0x00020010 aliases onto RAM byte 0x10.
        drive(1'b1, 1'b1, 32'h0002_0010, 8'h77);
        tick();
        drive(1'b1, 1'b0, 32'h10, 8'h00);
        tick();
        check("alias_data", data_to_ft, 8'h77);

        // Non-data I/O load reads zero with latency 1.
        drive(1'b1, 1'b0, IOB + 32'h8, 8'h00);
        #1 check("io_other_stall", 8'(is_stall_to_ft), 8'h00);
        tick();
        check("io_other_ready", 8'(is_ready_to_ft), 8'h01);
        check("io_other_data",  data_to_ft,         8'h00);

        // Fill TX with 8 bytes while the sink is not ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, IOB, 8'hC0 + 8'(i));
            #1 check("tx_fill_stall", 8'(is_stall_to_ft), 8'h00);
            tick();
        end
        check("tx_full_valid", 8'(io_tx_valid), 8'h01);
        check("tx_full_head",  io_tx_data,      8'hC0);

        // Status register (zero without the option) while TX is full and RX is empty.
        drive(1'b1, 1'b0, IOB + 32'h4, 8'h00);
        #1 check("status_stall", 8'(is_stall_to_ft), 8'h00);
        tick();
        check("status_ready", 8'(is_ready_to_ft), 8'h01);
        check("status_data",  data_to_ft,         status_exp);

        // Ninth store stalls until the sink takes one byte.
        drive(1'b1, 1'b1, IOB, 8'hC8);
        #1 check("tx9_stall_idle", 8'(is_stall_to_ft), 8'h01);
        tick();
        check("tx9_stall_wait1", 8'(is_stall_to_ft), 8'h01);
        tick();
        check("tx9_stall_wait2", 8'(is_stall_to_ft), 8'h01);
        io_tx_ready = 1'b1;
        #1 check("tx9_release", 8'(is_stall_to_ft), 8'h00);
        tick();
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        io_tx_ready = 1'b0;
        check("tx9_after_valid", 8'(io_tx_valid), 8'h01);
        check("tx9_after_head",  io_tx_data,      8'hC1);
        io_tx_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            check("tx_drain_order", io_tx_data, 8'hC0 + 8'(i));
            tick();
        end
        io_tx_ready = 1'b0;
        check("tx_drained", 8'(io_tx_valid), 8'h00);

        // RX load waits for a byte, then consumes it once.
        drive(1'b1, 1'b0, IOB, 8'h00);
        for (int i = 0; i < 5; i++) begin
            #1 check("rx_wait_stall", 8'(is_stall_to_ft), 8'h01);
            check("rx_wait_ready", 8'(is_ready_to_ft), 8'h00);
            tick();
        end
        io_rx_valid = 1'b1;
        io_rx_data  = 8'h5A;
        #1 check("rx_release", 8'(is_stall_to_ft), 8'h00);
        tick();
        check("rx_ready",    8'(is_ready_to_ft), 8'h01);
        check("rx_data",     data_to_ft,         8'h5A);
        check("rx_consumed", 8'(io_rx_ready),    8'h01);
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        io_rx_valid = 1'b0;
        tick();
        check("rx_pulse_end", 8'(io_rx_ready),    8'h00);
        check("rx_ready_end", 8'(is_ready_to_ft), 8'h00);

        // RX byte already present: no stall.
        io_rx_valid = 1'b1;
        io_rx_data  = 8'h3C;
        drive(1'b1, 1'b0, IOB, 8'h00);
        #1 check("rx_now_stall", 8'(is_stall_to_ft), 8'h00);
        tick();
        check("rx_now_data",     data_to_ft,      8'h3C);
        check("rx_now_consumed", 8'(io_rx_ready), 8'h01);
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        io_rx_valid = 1'b0;
        tick();

        // Asynchronous reset in RX_WAIT with three TX bytes queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, IOB, 8'hD0 + 8'(i));
            tick();
        end
        check("pre_rst_txvalid", 8'(io_tx_valid), 8'h01);
        drive(1'b1, 1'b0, IOB, 8'h00);
        tick();
        tick();
        check("pre_rst_stall", 8'(is_stall_to_ft), 8'h01);
        #1 rst = 1'b0;
        #1 check_all_zero("async_rst");
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        #2 rst = 1'b1;
        tick();
        check("post_rst_txvalid", 8'(io_tx_valid),    8'h00);
        check("post_rst_stall",   8'(is_stall_to_ft), 8'h00);
        drive(1'b1, 1'b0, 32'h10, 8'h00);
        tick();
        check("post_rst_ram_ready", 8'(is_ready_to_ft), 8'h01);
        check("post_rst_ram_data",  data_to_ft,         8'h77);
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        tick();

        // Stream 20 bytes through TX with the sink ready every other cycle.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 300 && got < 20; c++) begin
            if (sent < 20) drive(1'b1, 1'b1, IOB, 8'h40 + 8'(sent));
            else           drive(1'b0, 1'b0, 32'h0, 8'h0);
            io_tx_ready = (c % 2) == 1;
            #1;
            check("wrap_valid", 8'(io_tx_valid), 8'((q.size() != 0) ? 1 : 0));
            if (io_tx_valid && io_tx_ready) begin
                check("wrap_order", io_tx_data, (q.size() != 0) ? q[0] : 8'hEE);
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            accepted = is_valid_from_ft && !is_stall_to_ft;
            tick();
            if (accepted) begin
                q.push_back(data_from_ft);
                sent++;
            end
        end
        io_tx_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h0);
        check("wrap_count",   8'(got),         8'd20);
        check("wrap_drained", 8'(io_tx_valid), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
